// File: rtl/aes_pkg.sv
// AES inverse-cipher shared types, constants and GF(2^8) byte/column helpers.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int BLK_W  = 128;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion, instead of a lookup table.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] a);
    logic [BLK_W-1:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(a[127-8*i -: 8]);
    return o;
  endfunction

  // Byte index is row + 4*column; row r rotates right by r columns.
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] a);
    logic [BLK_W-1:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] a);
    logic [BLK_W-1:0] o;
    logic [7:0] s0, s1, s2, s3;
    for (int c = 0; c < 4; c++) begin
      s0 = a[127-32*c -: 8];
      s1 = a[119-32*c -: 8];
      s2 = a[111-32*c -: 8];
      s3 = a[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09);
      o[119-32*c -: 8] = gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d);
      o[111-32*c -: 8] = gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b);
      o[103-32*c -: 8] = gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/decrypt_round.sv
// One middle inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module decrypt_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] in,
  input  logic [BLK_W-1:0] key,
  output logic [BLK_W-1:0] out
);

  assign out = inv_mix_columns(inv_sub_bytes(inv_shift_rows(in)) ^ key);

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128 decryptor: one inverse round per clock, valid/ready on both sides.
module inv_cipher
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int W_WIDTH = 128 * (NR + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_W-1:0]   in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_WIDTH-1:0] w,
  output logic [BLK_W-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready
);

  fsm_t             st, st_n;
  logic             accept;
  logic [3:0]       rnd;
  logic [BLK_W-1:0] blk;
  logic [BLK_W-1:0] rk_cur;
  logic [BLK_W-1:0] round_out;
  logic [BLK_W-1:0] final_out;

  // Select the middle-round key for the current round counter.
  always_comb begin
    rk_cur = w[W_WIDTH-1-128 -: 128];
    for (int r = 1; r < NR; r++)
      if (rnd == 4'(r)) rk_cur = w[W_WIDTH-1-128*r -: 128];
  end

  decrypt_round u_round (
    .in  (blk),
    .key (rk_cur),
    .out (round_out)
  );

  // Last round has no InvMixColumns and uses the cipher key itself.
  assign final_out = inv_sub_bytes(inv_shift_rows(blk)) ^ w[W_WIDTH-1 -: 128];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_n;
  end

  // Next state and handshake; DONE accepts a new block on the edge the old one is taken.
  always_comb begin
    st_n     = st;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          st_n   = ROUND;
        end
      end
      ROUND: if (rnd == 4'd1) st_n = FINAL;
      FINAL: st_n = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept = 1'b1;
            st_n   = ROUND;
          end else begin
            st_n = IDLE;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Working state, round counter and registered plaintext.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk       <= '0;
      rnd       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        blk <= in ^ w[127:0];
        rnd <= 4'(NR - 1);
      end else if (st == ROUND) begin
        blk <= round_out;
        if (rnd != 4'd1) rnd <= rnd - 4'd1;
      end
      if (st == FINAL) begin
        out       <= final_out;
        out_valid <= 1'b1;
      end else if (st == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
